// File: rtl/mz_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// mz_cmd_sequencer
//
// Buffers upstream commands in a small FIFO and replays each one as a strobe
// sequence for a memory-zero controller.
//   op 0 (single write): one cycle of write with addr = lo and din = data,
//                        then a cmd_done pulse.
//   op 1 (zero range)  : ld_high (addr = hi), ld_low (addr = lo), zero on
//                        consecutive cycles. The controller must then raise
//                        busy, and cmd_done pulses the cycle after busy falls.
//                        A range with lo > hi is rejected with cmd_err and no
//                        strobes.
// Commands run strictly one at a time and in FIFO order.
//
// Timing (cycle 0 = first cycle after the accepting clock edge):
//   - The first strobe of a command appears at the earliest in cycle 1.
//   - busy is sampled in the three cycles after the zero strobe. If busy has
//     not been seen by then, cmd_err pulses in the fourth cycle after the zero
//     strobe.
//
// Parameters
//   ADDRWIDTH : controller address width
//   DATAWIDTH : controller data width
//   DEPTH     : command FIFO entries (power of two, >= 2)
//
// Ports
//   clock, reset         : clock and asynchronous active-low reset
//   cmd_valid/cmd_ready  : upstream handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_lo,
//   cmd_hi, cmd_data     : command payload
//   ld_high, ld_low,
//   write, zero          : registered one-cycle strobes to the controller
//   addr, din            : registered address/data; hold when no strobe is high
//   busy                 : controller busy flag
//   cmd_done, cmd_err    : registered one-cycle completion/error pulses
//   idle                 : FIFO empty and sequencer idle
// -----------------------------------------------------------------------------
module mz_cmd_sequencer #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [ADDRWIDTH-1:0] cmd_lo,
  input  logic [ADDRWIDTH-1:0] cmd_hi,
  input  logic [DATAWIDTH-1:0] cmd_data,
  output logic                 ld_high,
  output logic                 ld_low,
  output logic                 write,
  output logic                 zero,
  output logic [ADDRWIDTH-1:0] addr,
  output logic [DATAWIDTH-1:0] din,
  input  logic                 busy,
  output logic                 cmd_done,
  output logic                 cmd_err,
  output logic                 idle
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  // busy is looked at in WSTART cycles 0..WAIT_LAST. If it is still low in
  // the last of those cycles, the command is abandoned with cmd_err.
  localparam logic [1:0] WAIT_LAST = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_LDH,
    S_LDL,
    S_ZERO,
    S_WSTART,
    S_WDONE
  } state_e;

  typedef struct packed {
    logic                 op;
    logic [ADDRWIDTH-1:0] lo;
    logic [ADDRWIDTH-1:0] hi;
    logic [DATAWIDTH-1:0] data;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t            fifo_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            push, pop;
  logic            empty, full;
  cmd_t            head;
  cmd_t            cmd_in;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNTW'(DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    cmd_in.op   = cmd_op;
    cmd_in.lo   = cmd_lo;
    cmd_in.hi   = cmd_hi;
    cmd_in.data = cmd_data;
  end

  // NOTE: the storage array has no reset. Only the pointers and the count
  // decide which entries are valid, and leaving the array out of the reset
  // lets it map onto plain flops or RAM without a reset network.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cmd_in;
    end
  end

  // NOTE: every register below is updated with non-blocking assignments, so
  // all of them see pre-edge values. Blocking assignments here would make the
  // result depend on statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Because DEPTH is a power of two, the pointers wrap by plain overflow.
      if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [ADDRWIDTH-1:0]  cur_lo_q, cur_lo_d;
  logic [1:0]            wait_q, wait_d;
  logic                  write_q, write_d;
  logic                  ld_high_q, ld_high_d;
  logic                  ld_low_q, ld_low_d;
  logic                  zero_q, zero_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [DATAWIDTH-1:0]  din_q, din_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Each strobe and pulse is computed together with the transition into the
  // state it belongs to. That keeps every output a plain flop, with no
  // combinational path from any input.
  always_comb begin
    // NOTE: every output of this block gets a default first, so each path
    // through the case assigns everything and no latch can be inferred.
    state_d   = state_q;
    cur_lo_d  = cur_lo_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    din_d     = din_q;
    write_d   = 1'b0;
    ld_high_d = 1'b0;
    ld_low_d  = 1'b0;
    zero_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Never start a command while the controller still reports busy.
        if (!empty && !busy) begin
          pop      = 1'b1;
          cur_lo_d = head.lo;
          if (!head.op) begin
            state_d = S_WR;
            write_d = 1'b1;
            addr_d  = head.lo;
            din_d   = head.data;
          end else if (head.lo <= head.hi) begin
            state_d   = S_LDH;
            ld_high_d = 1'b1;
            addr_d    = head.hi;
          end else begin
            // Inverted range: reject it and stay ready for the next entry.
            err_d = 1'b1;
          end
        end
      end

      S_WR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      S_LDH: begin
        state_d  = S_LDL;
        ld_low_d = 1'b1;
        addr_d   = cur_lo_q;
      end

      S_LDL: begin
        state_d = S_ZERO;
        zero_d  = 1'b1;
        wait_d  = '0;
      end

      S_ZERO: begin
        state_d = S_WSTART;
      end

      S_WSTART: begin
        if (busy) begin
          state_d = S_WDONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_WDONE: begin
        if (!busy) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cur_lo_q  <= '0;
      wait_q    <= '0;
      write_q   <= 1'b0;
      ld_high_q <= 1'b0;
      ld_low_q  <= 1'b0;
      zero_q    <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_lo_q  <= cur_lo_d;
      wait_q    <= wait_d;
      write_q   <= write_d;
      ld_high_q <= ld_high_d;
      ld_low_q  <= ld_low_d;
      zero_q    <= zero_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign write    = write_q;
  assign ld_high  = ld_high_q;
  assign ld_low   = ld_low_q;
  assign zero     = zero_q;
  assign addr     = addr_q;
  assign din      = din_q;
  assign cmd_done = done_q;
  assign cmd_err  = err_q;
  assign idle     = empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_mz_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for mz_cmd_sequencer.
// When the bench issues a command, the reference model computes the full list
// of events that command must produce: each strobe or pulse, the absolute
// cycle it appears in, and the addr/din values expected with it. These go into
// a queue. A separate monitor compares every event the DUT produces against
// the head of that queue.
// A behavioural controller model drives busy in response to zero strobes. It
// follows a per-command plan: the delay before busy rises and how long it
// stays high, or no busy at all.
// -----------------------------------------------------------------------------
module tb_mz_cmd_sequencer;

  logic       clock, reset;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [7:0] cmd_lo, cmd_hi, cmd_data;
  logic       ld_high, ld_low, write, zero;
  logic [7:0] addr, din;
  logic       busy, cmd_done, cmd_err, idle;

  mz_cmd_sequencer #(.ADDRWIDTH(8), .DATAWIDTH(8), .DEPTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_lo   (cmd_lo),
    .cmd_hi   (cmd_hi),
    .cmd_data (cmd_data),
    .ld_high  (ld_high),
    .ld_low   (ld_low),
    .write    (write),
    .zero     (zero),
    .addr     (addr),
    .din      (din),
    .busy     (busy),
    .cmd_done (cmd_done),
    .cmd_err  (cmd_err),
    .idle     (idle)
  );

  typedef enum int {EV_WRITE, EV_LDH, EV_LDL, EV_ZERO, EV_DONE, EV_ERR, EV_NONE} ev_e;
  typedef struct {
    ev_e        kind;
    int         cyc;
    logic [7:0] addr;
    logic [7:0] din;
  } exp_t;
  // delay == 0: the controller never raises busy.
  typedef struct {
    int delay;
    int len;
  } plan_t;

  exp_t       exp_q[$];
  plan_t      plan_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         prev_end = 0;
  int         last_zero = 0;
  logic [7:0] hold_addr = 8'h00;
  logic [7:0] hold_din = 8'h00;
  bit         abort_busy = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Counts rising edges. At a falling edge, cyc holds the index of the cycle
  // currently on the outputs.
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic plan_t mk_plan(int d, int l);
    plan_t p;
    p.delay = d;
    p.len   = l;
    return p;
  endfunction

  function automatic void expect_ev(ev_e k, int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.addr = hold_addr;
    e.din  = hold_din;
    exp_q.push_back(e);
  endfunction

  // Reference model. Commands run one after another. A command accepted at
  // edge P shows its first event no earlier than cycle P+1, and no earlier
  // than one cycle after the previous command's done/err pulse.
  function automatic void model_accept(bit op, logic [7:0] lo, logic [7:0] hi,
                                       logic [7:0] data, plan_t p, int push_edge);
    int start;
    int z;
    start = (push_edge + 1 > prev_end + 1) ? push_edge + 1 : prev_end + 1;
    if (!op) begin
      hold_addr = lo;
      hold_din  = data;
      expect_ev(EV_WRITE, start);
      expect_ev(EV_DONE, start + 1);
      prev_end = start + 1;
    end else if (lo <= hi) begin
      z = start + 2;
      hold_addr = hi;
      expect_ev(EV_LDH, start);
      hold_addr = lo;
      expect_ev(EV_LDL, start + 1);
      expect_ev(EV_ZERO, z);
      last_zero = z;
      plan_q.push_back(p);
      if (p.delay == 0) begin
        expect_ev(EV_ERR, z + 4);
        prev_end = z + 4;
      end else begin
        // busy is high in cycles z+delay .. z+delay+len-1. done follows one
        // cycle after busy falls.
        expect_ev(EV_DONE, z + p.delay + p.len + 1);
        prev_end = z + p.delay + p.len + 1;
      end
    end else begin
      expect_ev(EV_ERR, start);
      prev_end = start;
    end
  endfunction

  task automatic send(input bit op, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [7:0] data, input plan_t p);
    int waited = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_lo    = lo;
    cmd_hi    = hi;
    cmd_data  = data;
    while (cmd_ready !== 1'b1 && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      check("send_ready_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    model_accept(op, lo, hi, data, p, cyc + 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 5000) begin
      @(negedge clock);
      b++;
    end
    check("drain_pending_events", exp_q.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  // Monitor: compares every observed event against the model's queue.
  always @(negedge clock) begin
    int   n;
    ev_e  k;
    exp_t e;
    if (reset) begin
      n = int'(write) + int'(ld_high) + int'(ld_low) + int'(zero) +
          int'(cmd_done) + int'(cmd_err);
      if (n > 1) check("one_event_per_cycle", n, 1);
      if (n != 0) begin
        k = write    ? EV_WRITE :
            ld_high  ? EV_LDH   :
            ld_low   ? EV_LDL   :
            zero     ? EV_ZERO  :
            cmd_done ? EV_DONE  : EV_ERR;
        if (write) check("write_while_busy", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_event", k, EV_NONE);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", k, e.kind);
          check("event_cycle", cyc, e.cyc);
          check("event_addr", {24'd0, addr}, {24'd0, e.addr});
          check("event_din", {24'd0, din}, {24'd0, e.din});
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missed_event_kind", EV_NONE, e.kind);
      end
    end
  end

  // Controller model: responds to each zero strobe according to its plan.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && zero) begin
        plan_t p;
        if (plan_q.size() == 0) begin
          check("plan_available", plan_q.size(), 1);
        end else begin
          p = plan_q.pop_front();
          if (p.delay > 0) begin
            repeat (p.delay) @(posedge clock);
            #1 busy = 1'b1;
            for (int i = 0; i < p.len; i++) begin
              @(posedge clock);
              if (abort_busy) break;
            end
            #1 busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int b;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_lo    = 8'h00;
    cmd_hi    = 8'h00;
    cmd_data  = 8'h00;

    // Reset state.
    #1;
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_strobes", {28'd0, write, ld_high, ld_low, zero}, 32'd0);
    check("rst_pulses", {30'd0, cmd_done, cmd_err}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_din", {24'd0, din}, 32'd0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    prev_end = cyc;

    // Single write.
    send(1'b0, 8'hAA, 8'h00, 8'h55, mk_plan(0, 0));
    wait_drain();
    check("idle_after_write", {31'd0, idle}, 32'd1);

    // Full-range zero with a 256-cycle busy.
    send(1'b1, 8'h00, 8'hFF, 8'h00, mk_plan(1, 256));
    wait_drain();
    check("idle_after_zero", {31'd0, idle}, 32'd1);

    // Backpressure: fill the FIFO while a long zero keeps busy high.
    send(1'b1, 8'h20, 8'h40, 8'h00, mk_plan(1, 100));
    b = 0;
    while (busy !== 1'b1 && b < 50) begin
      @(negedge clock);
      b++;
    end
    check("busy_raised", {31'd0, busy}, 32'd1);
    send(1'b0, 8'h11, 8'h00, 8'hA1, mk_plan(0, 0));
    send(1'b0, 8'h12, 8'h00, 8'hA2, mk_plan(0, 0));
    send(1'b1, 8'h30, 8'h35, 8'h00, mk_plan(2, 5));
    send(1'b0, 8'h13, 8'h00, 8'hA3, mk_plan(0, 0));
    @(negedge clock);
    check("ready_low_when_full", {31'd0, cmd_ready}, 32'd0);
    check("not_idle_when_full", {31'd0, idle}, 32'd0);
    send(1'b0, 8'h14, 8'h00, 8'hA4, mk_plan(0, 0));
    wait_drain();

    // Inverted range, then a normal write.
    send(1'b1, 8'h80, 8'h10, 8'h00, mk_plan(0, 0));
    send(1'b0, 8'h33, 8'h00, 8'h44, mk_plan(0, 0));
    wait_drain();

    // Timeout: busy never rises.
    send(1'b1, 8'h05, 8'h06, 8'h00, mk_plan(0, 0));
    wait_drain();

    // Reset while waiting for busy to fall.
    send(1'b1, 8'h00, 8'h10, 8'h00, mk_plan(1, 60));
    b = 0;
    while (cyc < last_zero + 8 && b < 500) begin
      @(negedge clock);
      b++;
    end
    #2 reset = 1'b0;
    abort_busy = 1'b1;
    exp_q.delete();
    plan_q.delete();
    #1;
    check("midrst_idle", {31'd0, idle}, 32'd1);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_pulses", {30'd0, cmd_done, cmd_err}, 32'd0);
    check("midrst_addr", {24'd0, addr}, 32'd0);
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    abort_busy = 1'b0;
    hold_addr  = 8'h00;
    hold_din   = 8'h00;
    prev_end   = cyc;
    repeat (10) @(negedge clock);
    check("postrst_idle", {31'd0, idle}, 32'd1);
    send(1'b0, 8'h77, 8'h00, 8'h88, mk_plan(0, 0));
    wait_drain();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      bit         op;
      logic [7:0] lo, hi, data;
      plan_t      p;
      op   = 1'($urandom_range(0, 1));
      lo   = 8'($urandom_range(0, 255));
      hi   = 8'($urandom_range(0, 255));
      data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) p = mk_plan(0, 0);
      else p = mk_plan(int'($urandom_range(1, 3)), int'($urandom_range(1, 12)));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send(op, lo, hi, data, p);
    end
    wait_drain();
    check("final_idle", {31'd0, idle}, 32'd1);
    check("final_plans_consumed", plan_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mz_cmd_sequencer.md
MZ_CMD_SEQUENCER -- requirements
Module: mz_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 8: address width of the downstream memory-zero controller.
REQ-002 SHALL have parameter DATAWIDTH, default 8: data width of the downstream memory-zero controller.
REQ-003 SHALL have parameter DEPTH, default 4 (power of two, >=2): command FIFO entries.
REQ-004 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port cmd_valid, input, 1: upstream command present.
REQ-007 SHALL have port cmd_ready, output, 1: FIFO can accept; a transfer occurs when cmd_valid & cmd_ready at the rising edge.
REQ-008 SHALL have port cmd_op, input, 1: 0 = single write, 1 = zero range.
REQ-009 SHALL have port cmd_lo, input, ADDRWIDTH: write address (op 0) or range low address (op 1).
REQ-010 SHALL have port cmd_hi, input, ADDRWIDTH: range high address (op 1 only; ignored for op 0).
REQ-011 SHALL have port cmd_data, input, DATAWIDTH: write data (op 0 only).
REQ-012 SHALL have ports ld_high, ld_low, write, zero, output, 1 each: one-cycle strobes to the controller.
REQ-013 SHALL have ports addr (output, ADDRWIDTH) and din (output, DATAWIDTH): registered address and data to the controller.
REQ-014 SHALL have port busy, input, 1: controller busy flag (zeroing in progress).
REQ-015 SHALL have ports cmd_done and cmd_err, output, 1 each: one-cycle completion and error pulses.
REQ-016 SHALL have port idle, output, 1: FIFO empty and FSM in IDLE.

Function
REQ-017 SHALL buffer commands in a DEPTH-entry FIFO; cmd_ready = !full; a simultaneous push and pop when full is not allowed (ready is already low); a simultaneous push and pop when non-empty keeps the count unchanged.
REQ-018 SHALL use FSM states IDLE, WR, LDH, LDL, ZERO, WSTART, WDONE, each holding one cycle except IDLE, WSTART and WDONE.
REQ-019 SHALL, in IDLE, pop the FIFO head only when the FIFO is non-empty and busy = 0; op 0 goes to WR; op 1 with lo <= hi goes to LDH; op 1 with lo > hi pulses cmd_err for 1 cycle, issues no strobes, and stays in IDLE.
REQ-020 SHALL, in WR, drive write = 1, addr = lo and din = data for 1 cycle, then pulse cmd_done in the next cycle and return to IDLE.
REQ-021 SHALL drive ld_high = 1 with addr = hi (LDH), then ld_low = 1 with addr = lo (LDL), then zero = 1 (ZERO), in consecutive cycles with exactly one strobe high per cycle.
REQ-022 SHALL, in WSTART, wait for busy = 1 and then go to WDONE; if busy is not seen within 4 cycles after ZERO, it SHALL pulse cmd_err and return to IDLE.
REQ-023 SHALL, in WDONE, wait for busy = 0, then pulse cmd_done and return to IDLE; there is no timeout in WDONE.
REQ-024 SHALL register all strobes, addr and din (no combinational path from inputs); addr and din SHALL hold their last values when no strobe is active.
REQ-025 SHALL never assert write, ld_high, ld_low or zero while the FSM is in WSTART or WDONE.
REQ-026 SHALL have a minimum latency from an accepted command into an empty FIFO with busy = 0 to its first strobe of 2 cycles (1 push, 1 pop/register).
REQ-027 SHALL wrap the FIFO pointers modulo DEPTH and track occupancy in a counter of width log2(DEPTH)+1.

Reset
REQ-028 SHALL, on reset = 0 (asynchronous), empty the FIFO, force FSM to IDLE, drive strobes, cmd_done and cmd_err to 0, drive addr and din to 0, and drive idle = 1 and cmd_ready = 1.
REQ-029 SHALL, on reset mid-operation, abandon the in-flight command with no cmd_done or cmd_err pulse.
REQ-030 SHALL release reset synchronously with no strobe in the first cycle after deassertion.

Verification
REQ-031 SHALL be verified with a write: op 0, lo = 0xAA, data = 0x55, busy = 0 -> exactly one write cycle with addr 0xAA and din 0x55, then cmd_done, then idle = 1.
REQ-032 SHALL be verified with a zero range: op 1, lo = 0x00, hi = 0xFF, and a model raising busy 1 cycle after zero for 256 cycles -> ld_high/addr 0xFF, then ld_low/addr 0x00, then zero on consecutive cycles; cmd_done 1 cycle after busy falls.
REQ-033 SHALL be verified with backpressure: push 5 commands during a long zero -> cmd_ready low after 4 entries; all 5 execute in order with no write during busy.
REQ-034 SHALL be verified with a bad range: op 1, lo = 0x80, hi = 0x10 -> cmd_err pulse, no strobes, next command proceeds normally.
REQ-035 SHALL be verified with a timeout and with reset: busy held 0 after zero -> cmd_err 4 cycles later; reset = 0 during WDONE -> idle = 1, FIFO empty, no done pulse.
